rd84_weight_enum: RTL

- Inverse of the rd84 weight-class functions. Given a target Hamming weight w, streams every WIDTH-bit vector whose popcount equals w, in ascending numeric order, over a valid/ready interface.
- Used as a stimulus source for exhaustive checking of the NOR-mapped rd84 outputs, and as a pattern source for MAGIC crossbar row initialisation.
- For WIDTH=8, weight w yields C(8,w) words; the word carrying out_last equals ((1<<w)-1) << (8-w).

---
 rtl/rd84_pkg.sv | 8 +
 rtl/rd84_popcount.sv | 18 +
 rtl/rd84_weight_enum.sv | 98 +++++++++
 3 files changed

// File: rtl/rd84_pkg.sv
// rd84_pkg: shared constants, FSM states and last-pattern helper for the rd84 weight enumerator
package rd84_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  function automatic logic [15:0] lastpat(input int w, input int width = DEF_WIDTH);
    return ((16'd1 << w) - 16'd1) << (width - w);
  endfunction
endpackage

// File: rtl/rd84_popcount.sv
// rd84_popcount: combinational popcount built as a recursive balanced adder tree
module rd84_popcount #(
  parameter int WIDTH = 8,
  parameter int WT_W  = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WT_W-1:0]  cnt
);
  if (WIDTH == 1) begin : g_leaf
    assign cnt = WT_W'(vec);
  end else begin : g_split
    localparam int LO = WIDTH / 2;
    logic [WT_W-1:0] lo_cnt, hi_cnt;
    rd84_popcount #(.WIDTH(LO), .WT_W(WT_W)) u_lo (.vec(vec[LO-1:0]), .cnt(lo_cnt));
    rd84_popcount #(.WIDTH(WIDTH-LO), .WT_W(WT_W)) u_hi (.vec(vec[WIDTH-1:LO]), .cnt(hi_cnt));
    assign cnt = lo_cnt + hi_cnt;
  end
endmodule

// File: rtl/rd84_weight_enum.sv
// rd84_weight_enum: streams every WIDTH-bit vector of a given popcount in ascending order
module rd84_weight_enum
  import rd84_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WT_W  = 4,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WT_W-1:0]  weight,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] out_count
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(1 << WIDTH);
  state_t          state;
  logic [WT_W-1:0] wt, pc;
  logic [WIDTH:0]  cand;
  logic            free, xfer, match, is_last;
  rd84_popcount #(.WIDTH(WIDTH), .WT_W(WT_W)) u_pc (.vec(cand[WIDTH-1:0]), .cnt(pc));
  // slot/handshake qualifiers and candidate classification, all from registered state
  always_comb begin
    free    = !out_valid || out_ready;
    xfer    = out_valid && out_ready;
    match   = !cand[WIDTH] && pc == wt;
    is_last = cand[WIDTH-1:0] == WIDTH'(lastpat(int'(wt), WIDTH));
  end
  // run control: one candidate per free edge, last match parks the FSM in DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wt        <= '0;
      cand      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_count <= '0;
    end else begin
      done <= 1'b0;
      if (xfer && out_count != MAX_CNT) out_count <= out_count + 1'b1;
      if (state != IDLE && abort) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
        err       <= 1'b0;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (weight > WT_W'(WIDTH)) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              wt        <= weight;
              cand      <= '0;
              out_count <= '0;
              err       <= 1'b0;
              busy      <= 1'b1;
              state     <= SCAN;
            end
          end
          SCAN: if (free) begin
            if (match) begin
              out_data  <= cand[WIDTH-1:0];
              out_valid <= 1'b1;
              out_last  <= is_last;
              if (is_last) state <= DRAIN;
              else cand <= cand + 1'b1;
            end else begin
              cand      <= cand + 1'b1;
              out_valid <= 1'b0;
            end
          end
          DRAIN: if (xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
